pwm_burst_array: RTL

//   Parametrised multi-channel PWM burst engine that replaces the fixed per-channel PWM instances behind the UART register mapper.

---
 rtl/pwm_burst_array.sv | 108 ++++++++++
 1 files changed

// File: rtl/pwm_burst_array.sv
// pwm_burst_array: multi-channel PWM burst engine with shadow configs and mask start/stop
module pwm_burst_array #(
    parameter int NUM_CH  = 6,
    parameter int CNT_W   = 16,
    parameter int PULSE_W = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cfg_wr,
    input  logic [7:0]         cfg_ch,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [PULSE_W-1:0] cfg_pulses,
    input  logic               cfg_pol,
    input  logic [NUM_CH-1:0]  start,
    input  logic [NUM_CH-1:0]  stop,
    output logic [NUM_CH-1:0]  pwm_out,
    output logic [NUM_CH-1:0]  pwm_busy,
    output logic [NUM_CH-1:0]  pwm_done,
    output logic               cfg_err
);
    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   high;
        logic [PULSE_W-1:0] pulses;
        logic               pol;
    } cfg_t;
    logic [1:0] rst_sync;
    logic       rst_n;
    cfg_t       wr_cfg;
    assign rst_n  = rst_sync[1];
    assign wr_cfg = '{cfg_period, cfg_high, cfg_pulses, cfg_pol};
    // Reset asserts immediately but releases two clocks after sys_rst_n rises
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    // Flag writes aimed at a channel that does not exist
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) cfg_err <= 1'b0;
        else cfg_err <= cfg_wr && cfg_ch >= 8'(NUM_CH);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             st, st_n;
        cfg_t               sh, sh_n, act, act_n;
        logic               dirty, dirty_n, done_n, wr, pend, last;
        logic               out, busy, done;
        logic [CNT_W-1:0]   cnt, cnt_n;
        logic [PULSE_W-1:0] pcnt, pcnt_n;
        assign wr          = cfg_wr && cfg_ch == 8'(i);
        assign pend        = cnt == act.period;
        assign last        = pend && act.pulses != '0 && pcnt == act.pulses - PULSE_W'(1);
        assign pwm_out[i]  = out;
        assign pwm_busy[i] = busy;
        assign pwm_done[i] = done;
        // Next state: stop beats start, start beats burst end, reloads only at period end
        always_comb begin
            sh_n    = wr ? wr_cfg : sh;
            dirty_n = wr | dirty;
            st_n    = st;
            act_n   = act;
            cnt_n   = cnt;
            pcnt_n  = pcnt;
            done_n  = 1'b0;
            if (st == RUN && stop[i]) begin
                st_n = IDLE;
            end else if (start[i] && !stop[i]) begin
                st_n    = RUN;
                act_n   = sh_n;
                dirty_n = 1'b0;
                cnt_n   = '0;
                pcnt_n  = '0;
            end else if (st == RUN) begin
                cnt_n  = pend ? '0 : cnt + CNT_W'(1);
                pcnt_n = pend ? pcnt + PULSE_W'(1) : pcnt;
                if (last) begin
                    st_n   = IDLE;
                    done_n = 1'b1;
                end else if (pend && dirty_n) begin
                    act_n   = sh_n;
                    dirty_n = 1'b0;
                end
            end
        end
        // Channel registers; the output is derived from next-cycle counter and config
        always_ff @(posedge sys_clk or negedge rst_n)
            if (!rst_n) begin
                st    <= IDLE;
                sh    <= '0;
                act   <= '0;
                dirty <= 1'b0;
                cnt   <= '0;
                pcnt  <= '0;
                out   <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                st    <= st_n;
                sh    <= sh_n;
                act   <= act_n;
                dirty <= dirty_n;
                cnt   <= cnt_n;
                pcnt  <= pcnt_n;
                out   <= st_n == RUN ? (cnt_n < act_n.high) ^ act_n.pol : act_n.pol;
                busy  <= st_n == RUN;
                done  <= done_n;
            end
    end
endmodule
